// File: rtl/grid_pkg.sv
// Shared definitions for the grid loader and the roll-removal solver:
// ASCII codes, loader state encoding and port-width helpers.
package grid_pkg;

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  typedef struct packed {
    logic is_roll;
    logic is_empty;
    logic is_eol;
    logic is_skip;
    logic is_bad;
  } char_class_t;

  // Row index width, never narrower than one bit.
  function automatic int RW(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int CW(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int NW(input int width, input int depth);
    return $clog2(width * depth + 1);
  endfunction

endpackage

// File: rtl/grid_stream_loader_if.sv
// Byte stream in and row write port out of the grid loader.
interface grid_stream_loader_if
  import grid_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 10
);

  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_data;
  logic                   in_last;
  logic                   wr_en;
  logic [RW(DEPTH)-1:0]   wr_row;
  logic [WIDTH-1:0]       wr_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_row, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_row, wr_data
  );

endinterface

// File: rtl/grid_char_decode.sv
// Classifies one puzzle-text byte into roll, empty, end-of-line, skip or bad.
module grid_char_decode
  import grid_pkg::*;
(
  input  logic [7:0]  data,
  output char_class_t cls
);

  always_comb begin
    cls = '0;
    case (data)
      CH_ROLL:  cls.is_roll  = 1'b1;
      CH_EMPTY: cls.is_empty = 1'b1;
      CH_LF:    cls.is_eol   = 1'b1;
      CH_CR:    cls.is_skip  = 1'b1;
      default:  cls.is_bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/grid_stream_loader.sv
// Builds a bit grid from the ASCII puzzle stream and writes each completed
// row to the grid store, tracking dimensions, roll count and format errors.
module grid_stream_loader
  import grid_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 10
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  grid_stream_loader_if.slave          bus,
  output logic                         done,
  output logic                         error,
  output logic [RW(DEPTH):0]           rows,
  output logic [CW(WIDTH)-1:0]         cols,
  output logic [NW(WIDTH, DEPTH)-1:0]  roll_count
);

  localparam int RWW = RW(DEPTH);
  localparam int CWW = CW(WIDTH);
  localparam int NWW = NW(WIDTH, DEPTH);

  state_t           state;
  logic             fin_q;
  logic [WIDTH-1:0] row_q;
  logic [CWW-1:0]   col_q;

  char_class_t      cls;
  logic             beat;
  logic             row_full;
  logic             char_ok;
  logic             byte_err;
  logic [WIDTH-1:0] bit_sel;
  logic [WIDTH-1:0] row_nxt;
  logic [CWW-1:0]   col_nxt;
  logic [NWW-1:0]   roll_nxt;
  logic             commit_req;
  logic             commit_err;

  grid_char_decode u_decode (
    .data (bus.in_data),
    .cls  (cls)
  );

  assign beat     = bus.in_valid & bus.in_ready;
  assign row_full = (col_q == CWW'(WIDTH));
  assign char_ok  = cls.is_skip | cls.is_eol | ((cls.is_roll | cls.is_empty) & ~row_full);
  assign byte_err = cls.is_bad | ~char_ok;
  assign bit_sel  = WIDTH'(1) << col_q;

  always_comb begin
    row_nxt  = row_q;
    col_nxt  = col_q;
    roll_nxt = roll_count;
    if (!byte_err && (cls.is_roll || cls.is_empty)) begin
      row_nxt = cls.is_roll ? (row_q | bit_sel) : (row_q & ~bit_sel);
      col_nxt = col_q + 1'b1;
      if (cls.is_roll) roll_nxt = roll_count + 1'b1;
    end
  end

  // A row closes on '\n' or, for an unterminated final line, on in_last.
  assign commit_req = !byte_err && (cls.is_eol || bus.in_last) && (col_nxt != '0);
  assign commit_err = ((rows != '0) && (col_nxt != cols)) ||
                      (rows == (RWW + 1)'(DEPTH));

  assign done  = (state == DONE);
  assign error = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fin_q        <= 1'b0;
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_row   <= '0;
      bus.wr_data  <= '0;
      row_q        <= '0;
      col_q        <= '0;
      rows         <= '0;
      cols         <= '0;
      roll_count   <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LOAD;
            fin_q        <= 1'b0;
            bus.in_ready <= 1'b1;
            row_q        <= '0;
            col_q        <= '0;
            rows         <= '0;
            cols         <= '0;
            roll_count   <= '0;
          end
        end
        LOAD: begin
          if (fin_q) begin
            state <= DONE;
            fin_q <= 1'b0;
          end else if (beat) begin
            if (byte_err) begin
              state        <= ERR;
              bus.in_ready <= 1'b0;
            end else begin
              roll_count <= roll_nxt;
              row_q      <= row_nxt;
              col_q      <= col_nxt;
              if (commit_req) begin
                if (rows == '0) cols <= col_nxt;
                if (commit_err) begin
                  state        <= ERR;
                  bus.in_ready <= 1'b0;
                end else begin
                  bus.wr_en   <= 1'b1;
                  bus.wr_row  <= rows[RWW-1:0];
                  bus.wr_data <= row_nxt;
                  rows        <= rows + 1'b1;
                  row_q       <= '0;
                  col_q       <= '0;
                  // DONE waits one cycle so it follows the final write strobe.
                  if (bus.in_last) begin
                    fin_q        <= 1'b1;
                    bus.in_ready <= 1'b0;
                  end
                end
              end else if (bus.in_last) begin
                state        <= (rows == '0) ? ERR : DONE;
                bus.in_ready <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
